game_load_seq: RTL and testbench
================================

Name: game_load_seq

Overview:
- Top-level game sequencer.
- Owns the single SD-card reader and grants it first to the chart (note-data) loader, then to the song (audio) loader, retrying on read errors.
- After both loads, runs a 3-2-1 countdown and releases play.
- Generates the game-wide pause and reset signals consumed by the note scroller, scorer and audio player.

Parameters:
- TICKS_PER_COUNT, 65000000: clk cycles per countdown step (1 s at 65 MHz).
- COUNT_STEPS, 3: countdown steps before PLAY; range 1..7.
- MAX_RETRY, 2: retries allowed per loader after sd_err; 0..3.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pause_SW  in  1  debounced pause switch level
- reset_trigger  in  1  debounced reset button level
- chart_done  in  1  chart loader finished, one-cycle pulse
- song_done  in  1  song loader finished, one-cycle pulse
- sd_err  in  1  SD read error from the currently granted loader, one-cycle pulse
- chart_start  out  1  one-cycle start pulse to chart loader
- song_start  out  1  one-cycle start pulse to song loader
- sd_grant  out  2  SD owner: 00 none, 01 chart, 10 song
- pause  out  1  1 = game frozen
- reset  out  1  one-cycle game reset pulse
- countdown  out  3  current countdown digit; 0 outside COUNTDOWN
- state  out  3  FSM state encoding, for display/debug
- load_fail  out  1  sticky; set in ERROR

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, all outputs 0 except pause=1.
  - Retry counter and tick counter cleared.
- All outputs registered. Start pulses and the reset pulse last exactly 1 cycle.
- States (encoding): IDLE 0, LOAD_CHART 1, LOAD_SONG 2, COUNTDOWN 3, PLAY 4, PAUSED 5, ERROR 6.
- IDLE: unconditionally go to LOAD_CHART the next cycle. chart_start=1 and sd_grant=01 in the first LOAD_CHART cycle.
- LOAD_CHART:
  - On chart_done: go to LOAD_SONG, sd_grant=10, song_start=1 in that cycle, retry counter cleared.
  - On sd_err:
    - If retry<MAX_RETRY: retry++ and re-pulse chart_start the next cycle, staying in state.
    - Otherwise: go to ERROR.
  - chart_done and sd_err in the same cycle: done wins.
- LOAD_SONG: same rules with song_done/song_start. On done: go to COUNTDOWN, sd_grant=00, countdown=COUNT_STEPS, tick counter=0.
- Done pulses from the non-granted loader are ignored in every state.
- COUNTDOWN:
  - Tick counter increments every cycle.
  - At TICKS_PER_COUNT-1 the counter wraps to 0 and countdown decrements.
  - When countdown would go 1->0: go to PLAY with countdown=0.
  - pause_SW=1 freezes the counter and digit (state stays COUNTDOWN).
- PLAY: pause=0. pause_SW=1 -> PAUSED next cycle.
- PAUSED:
  - pause=1.
  - reset_trigger=1 -> reset pulse for 1 cycle, then IDLE (full reload). Reset is only honoured in PAUSED, or in ERROR.
  - pause_SW=0 with reset_trigger=0 -> COUNTDOWN, restarting from COUNT_STEPS.
  - If pause_SW falls while reset_trigger=1: the reset wins.
- ERROR: load_fail=1, sd_grant=00, pause=1. reset_trigger=1 -> reset pulse, clear load_fail, go to IDLE.
- pause=1 in every state except PLAY.
- reset_trigger is a level. The reset pulse fires once per entry into the action; IDLE ignores reset_trigger.
- reset_n asserted mid-load drops sd_grant immediately (asynchronous). The loaders see no further start until release.

Test Plan:
- Release reset; chart_done at cycle 10, song_done at cycle 30; TICKS_PER_COUNT=4, COUNT_STEPS=3:
  - chart_start at cycle 1, sd_grant 01 then 10, song_start 1 cycle after chart_done.
  - countdown 3,2,1 for 4 cycles each.
  - pause falls exactly 12 cycles after the COUNTDOWN entry.
- Two sd_err during LOAD_CHART with MAX_RETRY=2 -> two extra chart_start pulses. A third sd_err -> state=6, load_fail=1, sd_grant=00.
- PLAY, pause_SW=1 -> pause=1 next cycle. Then pause_SW=0 -> countdown restarts at 3; PLAY only after 12 cycles.
- reset_trigger=1 during PLAY -> no reset pulse. In PAUSED -> reset high exactly 1 cycle, state returns to IDLE, then chart_start re-issued.
- chart_done and sd_err in the same cycle -> LOAD_SONG entered, retry not incremented. song_done during LOAD_CHART -> ignored.
- reset_n low during LOAD_SONG -> sd_grant=00, pause=1 with no clock edge. After release, the sequence restarts from chart_start.

Source files
------------

// File: rtl/game_load_seq.sv
// Top-level game sequencer: SD loads (chart then song) with retry, 3-2-1 countdown, play/pause/reset control.
// Latency: every output is registered and reflects the state entered on the preceding clk edge.
// Backpressure: none; loader done/error pulses are accepted only from the loader currently holding the SD grant.
module game_load_seq #(
    parameter int TICKS_PER_COUNT = 65000000,
    parameter int COUNT_STEPS     = 3,
    parameter int MAX_RETRY       = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pause_SW,
    input  logic       reset_trigger,
    input  logic       chart_done,
    input  logic       song_done,
    input  logic       sd_err,
    output logic       chart_start,
    output logic       song_start,
    output logic [1:0] sd_grant,
    output logic       pause,
    output logic       reset,
    output logic [2:0] countdown,
    output logic [2:0] state,
    output logic       load_fail
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_CHART = 3'd1,
        LOAD_SONG  = 3'd2,
        COUNTDOWN  = 3'd3,
        PLAY       = 3'd4,
        PAUSED     = 3'd5,
        ERROR      = 3'd6
    } state_t;

    localparam int             TW          = (TICKS_PER_COUNT > 1) ? $clog2(TICKS_PER_COUNT) : 1;
    localparam logic [TW-1:0]  TICK_LAST   = TW'(TICKS_PER_COUNT - 1);
    localparam logic [2:0]     STEPS       = 3'(COUNT_STEPS);
    localparam logic [1:0]     RETRY_MAX   = 2'(MAX_RETRY);
    localparam logic [1:0]     GRANT_NONE  = 2'b00;
    localparam logic [1:0]     GRANT_CHART = 2'b01;
    localparam logic [1:0]     GRANT_SONG  = 2'b10;

    state_t        state_q, state_d;
    logic [1:0]    retry_q, retry_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    digit_q, digit_d;
    logic [1:0]    grant_q, grant_d;
    logic          chart_start_q, chart_start_d;
    logic          song_start_q, song_start_d;
    logic          reset_q, reset_d;
    logic          pause_q, pause_d;
    logic          load_fail_q, load_fail_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            retry_q       <= '0;
            tick_q        <= '0;
            digit_q       <= '0;
            grant_q       <= GRANT_NONE;
            chart_start_q <= 1'b0;
            song_start_q  <= 1'b0;
            reset_q       <= 1'b0;
            pause_q       <= 1'b1;
            load_fail_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            retry_q       <= retry_d;
            tick_q        <= tick_d;
            digit_q       <= digit_d;
            grant_q       <= grant_d;
            chart_start_q <= chart_start_d;
            song_start_q  <= song_start_d;
            reset_q       <= reset_d;
            pause_q       <= pause_d;
            load_fail_q   <= load_fail_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        retry_d       = retry_q;
        tick_d        = tick_q;
        digit_d       = digit_q;
        grant_d       = grant_q;
        chart_start_d = 1'b0;
        song_start_d  = 1'b0;
        reset_d       = 1'b0;
        load_fail_d   = load_fail_q;

        case (state_q)
            IDLE: begin
                state_d       = LOAD_CHART;
                grant_d       = GRANT_CHART;
                chart_start_d = 1'b1;
                retry_d       = '0;
            end
            LOAD_CHART: begin
                // done outranks a simultaneous error
                if (chart_done) begin
                    state_d      = LOAD_SONG;
                    grant_d      = GRANT_SONG;
                    song_start_d = 1'b1;
                    retry_d      = '0;
                end else if (sd_err) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d       = retry_q + 2'd1;
                        chart_start_d = 1'b1;
                    end else begin
                        state_d     = ERROR;
                        grant_d     = GRANT_NONE;
                        load_fail_d = 1'b1;
                    end
                end
            end
            LOAD_SONG: begin
                if (song_done) begin
                    state_d = COUNTDOWN;
                    grant_d = GRANT_NONE;
                    digit_d = STEPS;
                    tick_d  = '0;
                    retry_d = '0;
                end else if (sd_err) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d      = retry_q + 2'd1;
                        song_start_d = 1'b1;
                    end else begin
                        state_d     = ERROR;
                        grant_d     = GRANT_NONE;
                        load_fail_d = 1'b1;
                    end
                end
            end
            COUNTDOWN: begin
                if (!pause_SW) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (digit_q <= 3'd1) begin
                            state_d = PLAY;
                            digit_d = 3'd0;
                        end else begin
                            digit_d = digit_q - 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            PLAY: begin
                if (pause_SW) state_d = PAUSED;
            end
            PAUSED: begin
                if (reset_trigger) begin
                    state_d = IDLE;
                    reset_d = 1'b1;
                end else if (!pause_SW) begin
                    state_d = COUNTDOWN;
                    digit_d = STEPS;
                    tick_d  = '0;
                end
            end
            ERROR: begin
                if (reset_trigger) begin
                    state_d     = IDLE;
                    reset_d     = 1'b1;
                    load_fail_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = GRANT_NONE;
            end
        endcase

        pause_d = (state_d != PLAY);
    end

    assign chart_start = chart_start_q;
    assign song_start  = song_start_q;
    assign sd_grant    = grant_q;
    assign pause       = pause_q;
    assign reset       = reset_q;
    assign countdown   = digit_q;
    assign state       = state_q;
    assign load_fail   = load_fail_q;

endmodule

// File: tb/tb_game_load_seq.sv
// Bench for game_load_seq: vector table, directed timing sequences, randomized run against a reference model.
// Latency: outputs sampled 1 ns after each rising clk edge; inputs change at the same instant.
// Backpressure: not applicable; loader pulses are driven freely by the bench.
module tb_game_load_seq;
    localparam int T  = 4;
    localparam int C  = 3;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pause_sw = 1'b0, reset_trigger = 1'b0;
    logic       chart_done = 1'b0, song_done = 1'b0, sd_err = 1'b0;
    logic       chart_start, song_start, pause, game_rst, load_fail;
    logic [1:0] sd_grant;
    logic [2:0] countdown, state;

    int n_cmp = 0;
    int n_fail = 0;

    game_load_seq #(.TICKS_PER_COUNT(T), .COUNT_STEPS(C), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset_n(reset_n), .pause_SW(pause_sw), .reset_trigger(reset_trigger),
        .chart_done(chart_done), .song_done(song_done), .sd_err(sd_err),
        .chart_start(chart_start), .song_start(song_start), .sd_grant(sd_grant),
        .pause(pause), .reset(game_rst), .countdown(countdown), .state(state), .load_fail(load_fail)
    );

    always #5 clk = ~clk;

    // packed view: {state, grant, countdown, pause, chart_start, song_start, reset, load_fail}
    typedef struct {
        logic [4:0]  in;   // {chart_done, song_done, sd_err, pause_SW, reset_trigger}
        int          n;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(int in, int n, int st, int gr, int cdn, int fl);
        vec_t r;
        r.in  = 5'(in);
        r.n   = n;
        r.exp = {3'(st), 2'(gr), 3'(cdn), 5'(fl)};
        return r;
    endfunction

    function automatic logic [12:0] outs();
        return {state, sd_grant, countdown, pause, chart_start, song_start, game_rst, load_fail};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {chart_done, song_done, sd_err, pause_sw, reset_trigger} = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Reference model: a countdown is tracked as elapsed unfrozen cycles, digit = C - elapsed/T.
    int         m_state, m_att, m_el;
    logic [1:0] m_grant;
    logic       m_fail, m_cs, m_ss, m_rst;

    function automatic void model_reset();
        m_state = 0; m_att = 0; m_el = 0; m_grant = 2'd0;
        m_fail = 1'b0; m_cs = 1'b0; m_ss = 1'b0; m_rst = 1'b0;
    endfunction

    function automatic void model_step();
        m_cs = 1'b0; m_ss = 1'b0; m_rst = 1'b0;
        case (m_state)
            0: begin m_state = 1; m_cs = 1'b1; m_grant = 2'd1; m_att = 0; end
            1: if (chart_done) begin
                   m_state = 2; m_grant = 2'd2; m_ss = 1'b1; m_att = 0;
               end else if (sd_err) begin
                   if (m_att < MR) begin m_att++; m_cs = 1'b1; end
                   else begin m_state = 6; m_grant = 2'd0; m_fail = 1'b1; end
               end
            2: if (song_done) begin
                   m_state = 3; m_grant = 2'd0; m_el = 0; m_att = 0;
               end else if (sd_err) begin
                   if (m_att < MR) begin m_att++; m_ss = 1'b1; end
                   else begin m_state = 6; m_grant = 2'd0; m_fail = 1'b1; end
               end
            3: if (!pause_sw) begin
                   m_el++;
                   if (m_el == C * T) m_state = 4;
               end
            4: if (pause_sw) m_state = 5;
            5: if (reset_trigger) begin m_state = 0; m_rst = 1'b1; end
               else if (!pause_sw) begin m_state = 3; m_el = 0; end
            6: if (reset_trigger) begin m_state = 0; m_rst = 1'b1; m_fail = 1'b0; end
            default: m_state = 0;
        endcase
    endfunction

    function automatic logic [12:0] model_exp();
        logic [2:0] d;
        d = (m_state == 3) ? 3'(C - m_el / T) : 3'd0;
        return {3'(m_state), m_grant, d, (m_state != 4), m_cs, m_ss, m_rst, m_fail};
    endfunction

    initial begin
        // inputs {cd,sn,er,psw,rtr}; expected flags {pause,cs,ss,rst,fail}
        tbl.push_back(v('b00000, 1, 1, 1, 0, 'b11000));
        tbl.push_back(v('b00000, 1, 1, 1, 0, 'b10000));
        tbl.push_back(v('b00100, 1, 1, 1, 0, 'b11000));
        tbl.push_back(v('b00100, 1, 1, 1, 0, 'b11000));
        tbl.push_back(v('b10100, 1, 2, 2, 0, 'b10100));
        tbl.push_back(v('b10000, 1, 2, 2, 0, 'b10000));
        tbl.push_back(v('b00100, 1, 2, 2, 0, 'b10100));
        tbl.push_back(v('b01000, 1, 3, 0, 3, 'b10000));
        tbl.push_back(v('b00000, 3, 3, 0, 3, 'b10000));
        tbl.push_back(v('b00000, 1, 3, 0, 2, 'b10000));
        tbl.push_back(v('b00010, 5, 3, 0, 2, 'b10000));
        tbl.push_back(v('b00000, 3, 3, 0, 2, 'b10000));
        tbl.push_back(v('b00000, 1, 3, 0, 1, 'b10000));
        tbl.push_back(v('b00000, 3, 3, 0, 1, 'b10000));
        tbl.push_back(v('b00000, 1, 4, 0, 0, 'b00000));
        tbl.push_back(v('b00001, 2, 4, 0, 0, 'b00000));
        tbl.push_back(v('b00010, 1, 5, 0, 0, 'b10000));
        tbl.push_back(v('b00010, 3, 5, 0, 0, 'b10000));
        tbl.push_back(v('b00000, 1, 3, 0, 3, 'b10000));
        tbl.push_back(v('b00000, 11, 3, 0, 1, 'b10000));
        tbl.push_back(v('b00000, 1, 4, 0, 0, 'b00000));
        tbl.push_back(v('b00010, 1, 5, 0, 0, 'b10000));
        tbl.push_back(v('b00001, 1, 0, 0, 0, 'b10010));
        tbl.push_back(v('b00001, 1, 1, 1, 0, 'b11000));
        tbl.push_back(v('b00100, 1, 1, 1, 0, 'b11000));
        tbl.push_back(v('b00100, 1, 1, 1, 0, 'b11000));
        tbl.push_back(v('b00100, 1, 6, 0, 0, 'b10001));
        tbl.push_back(v('b00000, 2, 6, 0, 0, 'b10001));
        tbl.push_back(v('b00001, 1, 0, 0, 0, 'b10010));
        tbl.push_back(v('b00000, 1, 1, 1, 0, 'b11000));
        tbl.push_back(v('b01000, 1, 1, 1, 0, 'b10000));
        tbl.push_back(v('b10000, 1, 2, 2, 0, 'b10100));
        tbl.push_back(v('b00100, 1, 2, 2, 0, 'b10100));
        tbl.push_back(v('b00100, 1, 2, 2, 0, 'b10100));
        tbl.push_back(v('b00100, 1, 6, 0, 0, 'b10001));
        tbl.push_back(v('b00001, 1, 0, 0, 0, 'b10010));
        tbl.push_back(v('b00000, 1, 1, 1, 0, 'b11000));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), 13'b000_00_000_10000);

        do_reset();
        chk("idle_cycle0", outs(), 13'b000_00_000_10000);
        for (int i = 0; i < tbl.size(); i++) begin
            {chart_done, song_done, sd_err, pause_sw, reset_trigger} = tbl[i].in;
            tick();
            {chart_done, song_done, sd_err} = '0;
            for (int k = 1; k < tbl[i].n; k++) tick();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        begin
            int first_cs, n_cs, first_ss, first_cd, first_play, c3, c2, c1;
            logic [1:0] g5, g20;
            first_cs = -1; first_ss = -1; first_cd = -1; first_play = -1;
            n_cs = 0; c3 = 0; c2 = 0; c1 = 0; g5 = 2'd3; g20 = 2'd3;
            do_reset();
            for (int c = 0; c < 60; c++) begin
                if (chart_start) begin n_cs++; if (first_cs < 0) first_cs = c; end
                if (song_start && first_ss < 0) first_ss = c;
                if (state == 3'd3 && first_cd < 0) first_cd = c;
                if (!pause && first_play < 0) first_play = c;
                if (state == 3'd3) begin
                    if (countdown == 3'd3) c3++;
                    if (countdown == 3'd2) c2++;
                    if (countdown == 3'd1) c1++;
                end
                if (c == 5) g5 = sd_grant;
                if (c == 20) g20 = sd_grant;
                chart_done = (c == 10);
                song_done  = (c == 30);
                tick();
            end
            {chart_done, song_done} = '0;
            chk("seq_first_chart_start", first_cs, 1);
            chk("seq_chart_start_count", n_cs, 1);
            chk("seq_first_song_start", first_ss, 11);
            chk("seq_countdown_entry", first_cd, 31);
            chk("seq_pause_fall", first_play, 43);
            chk("seq_digit3_cycles", c3, 4);
            chk("seq_digit2_cycles", c2, 4);
            chk("seq_digit1_cycles", c1, 4);
            chk("seq_grant_chart", g5, 1);
            chk("seq_grant_song", g20, 2);
        end

        begin
            int extra;
            extra = 0;
            do_reset();
            tick(); tick();
            chart_done = 1'b1; tick(); chart_done = 1'b0;
            tick();
            chk("async_pre_state", state, 2);
            #2 reset_n = 1'b0;
            #1;
            chk("async_grant", sd_grant, 0);
            chk("async_pause", pause, 1);
            chk("async_state", state, 0);
            repeat (3) begin tick(); extra += int'(chart_start); end
            chk("async_no_start", extra, 0);
            reset_n = 1'b1;
            tick();
            chk("async_restart", outs(), 13'b001_01_000_11000);
        end

        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            chart_done = ($urandom_range(0, 7) == 0);
            song_done  = ($urandom_range(0, 7) == 0);
            sd_err     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) pause_sw = ~pause_sw;
            if ($urandom_range(0, 29) == 0) reset_trigger = ~reset_trigger;
            model_step();
            tick();
            chk($sformatf("rand%0d", i), outs(), model_exp());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
